posit_decode: RTL
=================

POSIT_DECODE -- requirements
Module: posit_decode

Interface
REQ-001 Parameter N, default 16: posit width in bits.
REQ-002 Parameter ES, default 3: exponent field width; derived FW = N-3-ES (fraction width) and SW = $clog2(N*2^ES)+1 (scale width).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  posit word offered.
REQ-007 in_ready  output  1  block can accept a word.
REQ-008 posit  input  N  posit word to decode.
REQ-009 out_valid  output  1  decoded fields valid.
REQ-010 out_ready  input  1  consumer takes the fields.
REQ-011 sign  output  1  sign bit of the accepted posit.
REQ-012 is_zero  output  1  accepted word was all zeros.
REQ-013 is_nar  output  1  accepted word was 1 followed by N-1 zeros (NaR/infinity).
REQ-014 scale  output  SW  signed, k*2^ES + e.
REQ-015 frac  output  FW  fraction bits after the hidden bit, left-aligned, zero-padded.

Function
REQ-016 FSM states IDLE, SCAN, EMIT; in_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance = in_valid && in_ready at a rising edge; posit is captured there and later changes are ignored.
REQ-018 On acceptance of zero or NaR: set the flag, sign = posit[N-1], scale = 0, frac = 0, go to EMIT.
REQ-019 On other acceptance: store magnitude (two's complement of posit if posit[N-1] = 1) bits [N-2:0] in a shift register; polarity = bit N-2; run count m = 0; go to SCAN.
REQ-020 SCAN consumes one bit per edge from the MSB of the shift register:
- bit equal to polarity: m increments, shift left with zero fill;
- bit unequal: the terminator is consumed and the block goes to EMIT.
REQ-021 If m reaches N-1 with no terminator, the block SHALL go to EMIT on that edge.
REQ-022 On entry to EMIT, fields SHALL be set as follows:
- k = m-1 if polarity = 1, else k = -m;
- e = the next ES remaining bits, with missing bits read as 0;
- frac = the following FW bits;
- scale = k*2^ES + e, sign-extended to SW.
REQ-023 Latency from the acceptance edge T0 to out_valid rising:
- zero/NaR: T0+1;
- run m < N-1: T0+m+1;
- m = N-1: T0+N-1.
REQ-024 In EMIT, out_valid = 1 and all outputs SHALL hold stable until out_valid && out_ready; on that edge go to IDLE and drop out_valid.
REQ-025 out_ready asserted in IDLE or SCAN SHALL have no effect.
REQ-026 No overlap: a new word SHALL NOT be accepted on the EMIT handoff edge; it is accepted in IDLE at the earliest one cycle later.
REQ-027 out_valid SHALL be deasserted in IDLE and SCAN; field outputs there SHALL keep their last EMIT values.

Reset
REQ-028 rst_n low SHALL immediately, without a clock edge, force IDLE, in_ready = 1, out_valid = 0, and sign, is_zero, is_nar, scale, frac = 0.
REQ-029 A reset during SCAN or EMIT SHALL abandon the word with no output; after release the first in_valid is accepted normally.

Verification (N=16, ES=3)
REQ-030 Word 0100000000000000 (1.0) -> out_valid at T0+2, sign 0, scale 0, frac 0.
REQ-031 Word 0100100000000000 (4) -> scale 2; word 0101000000000000 (16) -> scale 4; word 0100001000000000 (1.5) -> scale 0, frac 1000000000.
REQ-032 Word 1011010000000000 (-8) -> sign 1, scale 3, frac 0; word 1100000000000000 (-1) -> sign 1, scale 0.
REQ-033 Word 0000000000000000 -> is_zero = 1 at T0+1; word 1000000000000000 -> is_nar = 1, sign 1 at T0+1.
REQ-034 Word 0111111111111111 -> scale 112 at T0+15; word 0000000000000001 -> scale -112 at T0+15.
REQ-035 Stress cases:
- hold out_ready = 0 for 5 cycles in EMIT -> outputs stable and in_ready = 0;
- pulse rst_n low mid-SCAN -> out_valid stays 0 and the next word decodes correctly.

Source files
------------

// File: rtl/posit_decode.sv
// rtl/posit_decode.sv - serial posit field decoder (sign, zero/NaR flags, scale, fraction)
module posit_decode #(
  parameter int N  = 16,
  parameter int ES = 3,
  localparam int FW = N - 3 - ES,
  localparam int SW = $clog2(N * (2 ** ES)) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         posit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sign,
  output logic                 is_zero,
  output logic                 is_nar,
  output logic signed [SW-1:0] scale,
  output logic [FW-1:0]        frac
);

  localparam int MW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t                state_q, state_d;
  logic [N-2:0]          sr_q, sr_d;
  logic                  pol_q, pol_d;
  logic [MW-1:0]         m_q, m_d;
  logic                  sgn_q, sgn_d;
  logic                  sign_q, sign_d;
  logic                  zero_q, zero_d;
  logic                  nar_q, nar_d;
  logic signed [SW-1:0]  scale_q, scale_d;
  logic [FW-1:0]         frac_q, frac_d;

  logic [N-2:0]          mag;
  logic [ES+FW-1:0]      rest;
  logic [MW-1:0]         m_fin;
  logic [SW-1:0]         k_v;
  logic                  fin;

  // State and field registers; reset clears everything without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      pol_q   <= 1'b0;
      m_q     <= '0;
      sgn_q   <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      nar_q   <= 1'b0;
      scale_q <= '0;
      frac_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pol_q   <= pol_d;
      m_q     <= m_d;
      sgn_q   <= sgn_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      nar_q   <= nar_d;
      scale_q <= scale_d;
      frac_q  <= frac_d;
    end
  end

  // Next state: accept in IDLE, scan one regime bit per cycle, then present fields in EMIT
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pol_d   = pol_q;
    m_d     = m_q;
    sgn_d   = sgn_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    nar_d   = nar_q;
    scale_d = scale_q;
    frac_d  = frac_q;
    fin     = 1'b0;
    m_fin   = m_q;
    rest    = '0;
    k_v     = '0;
    // Low N-1 bits of the two's complement are all the scan needs
    mag     = posit[N-1] ? (~posit[N-2:0] + {{(N-2){1'b0}}, 1'b1}) : posit[N-2:0];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (posit[N-2:0] == '0) begin
            // Zero and NaR share the all-zero tail; the top bit tells them apart
            sign_d  = posit[N-1];
            zero_d  = ~posit[N-1];
            nar_d   = posit[N-1];
            scale_d = '0;
            frac_d  = '0;
            state_d = EMIT;
          end else begin
            sgn_d   = posit[N-1];
            sr_d    = mag;
            pol_d   = mag[N-2];
            m_d     = '0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (sr_q[N-2] == pol_q) begin
          m_d  = m_q + MW'(1);
          sr_d = sr_q << 1;
          if (m_q + MW'(1) == MW'(N - 1)) begin
            // Regime fills the word: no exponent or fraction bits remain
            fin   = 1'b1;
            m_fin = MW'(N - 1);
            rest  = '0;
          end
        end else begin
          // Terminator is at the MSB; everything below it is exponent then fraction
          fin   = 1'b1;
          m_fin = m_q;
          rest  = sr_q[N-3:N-2-ES-FW];
        end
        if (fin) begin
          k_v     = pol_q ? (SW'(m_fin) - SW'(1)) : (SW'(0) - SW'(m_fin));
          scale_d = (k_v << ES) + SW'(rest[ES+FW-1:FW]);
          frac_d  = rest[FW-1:0];
          sign_d  = sgn_q;
          zero_d  = 1'b0;
          nar_d   = 1'b0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign sign      = sign_q;
  assign is_zero   = zero_q;
  assign is_nar    = nar_q;
  assign scale     = scale_q;
  assign frac      = frac_q;

endmodule
